// File: rtl/hash_feeder_pkg.sv
// Shared types and helpers for the hash message feeder.
//   feeder_state_t : top-level sequencing states
//   cnt_width()    : width of a down-counter able to hold the larger of two loads
package hash_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARMUP = 3'd1,
        ST_FEED   = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } feeder_state_t;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/hash_bit_serializer.sv
// MSB-first parallel-to-serial stage feeding the hash core injector bit.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   en            : high while the feeder is in FEED; low clears the stage
//   s_data/s_valid/s_last/s_ready : message word stream
//   bit_valid     : a data bit is pending this cycle (bit_out is meaningful)
//   bit_out       : current MSB of the shift register
//   bubble        : no bit available and no word arriving before last was seen
//   last_bit      : bit_out is the final bit of the final word
module hash_bit_serializer
    import hash_feeder_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              bit_valid,
    output logic              bit_out,
    output logic              bubble,
    output logic              last_bit
);

    localparam int BL_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sr_q, sr_d;
    logic [BL_W-1:0]   bits_left_q, bits_left_d;
    logic              last_pending_q, last_pending_d;
    logic              hs;

    // Accepting at bits_left==1 lets the next word load on the same edge the
    // current word's final bit is driven, so consecutive words have no gap.
    always_comb begin
        s_ready   = en && (bits_left_q <= BL_W'(1)) && !last_pending_q;
        hs        = s_valid && s_ready;
        bit_valid = en && (bits_left_q != '0);
        bit_out   = sr_q[DATA_W-1];
        bubble    = en && (bits_left_q == '0) && !hs && !last_pending_q;
        last_bit  = en && (bits_left_q == BL_W'(1)) && last_pending_q;
    end

    always_comb begin
        sr_d           = sr_q;
        bits_left_d    = bits_left_q;
        last_pending_d = last_pending_q;
        if (!en) begin
            sr_d           = '0;
            bits_left_d    = '0;
            last_pending_d = 1'b0;
        end else begin
            if (bits_left_q != '0) begin
                sr_d        = {sr_q[DATA_W-2:0], 1'b0};
                bits_left_d = bits_left_q - BL_W'(1);
            end
            if (hs) begin
                sr_d           = s_data;
                bits_left_d    = BL_W'(DATA_W);
                last_pending_d = s_last;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q           <= '0;
            bits_left_q    <= '0;
            last_pending_q <= 1'b0;
        end else begin
            sr_q           <= sr_d;
            bits_left_q    <= bits_left_d;
            last_pending_q <= last_pending_d;
        end
    end

endmodule

// File: rtl/hash_message_feeder.sv
// Initiator-side driver for the programmable hash core. Holds the core in
// reset while idle, releases it for a warm-up, serializes message words onto
// the injector bit, pads with zeros, then captures core_O as the digest.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start, busy           : begin a hash (sampled in IDLE) / not idle
//   s_data/s_valid/s_last/s_ready : message word stream
//   core_reset, core_injector     : registered drives into the hash core
//   core_O                : hash core output
//   digest/digest_valid/digest_ready : captured result handshake
//   underrun              : sticky, a bubble bit was injected in this hash
//
// state  | meaning
// IDLE   | core held in reset, waiting for start
// WARMUP | core released, config registers settling
// FEED   | message bits shifted onto the injector
// FLUSH  | zero padding injected
// DONE   | digest presented until accepted
module hash_message_feeder
    import hash_feeder_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int OUT_SIZE      = 32,
    parameter int WARMUP_CYCLES = 64,
    parameter int FLUSH_CYCLES  = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,
    output logic                core_reset,
    output logic                core_injector,
    input  logic [OUT_SIZE-1:0] core_O,
    output logic [OUT_SIZE-1:0] digest,
    output logic                digest_valid,
    input  logic                digest_ready,
    output logic                underrun
);

    localparam int CNT_W = cnt_width(WARMUP_CYCLES, FLUSH_CYCLES);

    feeder_state_t       state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                core_reset_q, core_reset_d;
    logic                core_injector_q, core_injector_d;
    logic [OUT_SIZE-1:0] digest_q, digest_d;
    logic                digest_valid_q, digest_valid_d;
    logic                underrun_q, underrun_d;

    logic ser_en, bit_valid, bit_out, bubble, last_bit;

    assign ser_en = (state_q == ST_FEED);

    hash_bit_serializer #(.DATA_W(DATA_W)) u_serializer (
        .clk       (clk),
        .rst       (reset),
        .en        (ser_en),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .bit_valid (bit_valid),
        .bit_out   (bit_out),
        .bubble    (bubble),
        .last_bit  (last_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            core_reset_q    <= 1'b1;
            core_injector_q <= 1'b0;
            digest_q        <= '0;
            digest_valid_q  <= 1'b0;
            underrun_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            core_reset_q    <= core_reset_d;
            core_injector_q <= core_injector_d;
            digest_q        <= digest_d;
            digest_valid_q  <= digest_valid_d;
            underrun_q      <= underrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WARMUP;
                    cnt_d   = CNT_W'(WARMUP_CYCLES - 1);
                end
            end
            ST_WARMUP: begin
                if (cnt_q == '0) state_d = ST_FEED;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_FEED: begin
                if (last_bit) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            ST_FLUSH: begin
                if (cnt_q == '0) state_d = ST_DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_DONE: begin
                if (digest_valid_q && digest_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        core_reset_d    = core_reset_q;
        core_injector_d = 1'b0;
        digest_d        = digest_q;
        digest_valid_d  = digest_valid_q;
        underrun_d      = underrun_q;
        case (state_q)
            ST_IDLE: begin
                core_reset_d = 1'b1;
                if (start) begin
                    core_reset_d = 1'b0;
                    underrun_d   = 1'b0;
                end
            end
            ST_FEED: begin
                if (bit_valid) core_injector_d = bit_out;
                if (bubble)    underrun_d      = 1'b1;
            end
            ST_FLUSH: begin
                if (cnt_q == '0) begin
                    digest_d       = core_O;
                    digest_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (digest_valid_q && digest_ready) begin
                    digest_valid_d = 1'b0;
                    core_reset_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy          = (state_q != ST_IDLE);
    assign core_reset    = core_reset_q;
    assign core_injector = core_injector_q;
    assign digest        = digest_q;
    assign digest_valid  = digest_valid_q;
    assign underrun      = underrun_q;

endmodule

// File: tb/tb_hash_message_feeder.sv
module tb_hash_message_feeder;

    localparam int DW = 8;
    localparam int OW = 32;
    localparam int WU = 4;
    localparam int FL = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          digest_ready = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic [OW-1:0] core_o = '0;
    logic          busy, s_ready, core_reset, core_injector, digest_valid, underrun;
    logic [OW-1:0] digest;

    always #5 clk = ~clk;

    hash_message_feeder #(
        .DATA_W(DW), .OUT_SIZE(OW), .WARMUP_CYCLES(WU), .FLUSH_CYCLES(FL)
    ) dut (
        .clk(clk), .reset(rst), .start(start), .busy(busy),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .core_reset(core_reset), .core_injector(core_injector), .core_O(core_o),
        .digest(digest), .digest_valid(digest_valid), .digest_ready(digest_ready),
        .underrun(underrun)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic          cr, inj, rdy, bz, dv, und;
        logic [OW-1:0] dig;
    } rec_t;

    rec_t          exp_q[$];
    rec_t          ce;
    logic [DW-1:0] w_arr[8];
    int            d_arr[8];
    logic [OW-1:0] prev_dig = '0;
    logic [31:0]   inj_log;

    task automatic chk_b(input string nm, input logic act, input logic expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: actual %b expected %b at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: actual %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic rec_t mk(input logic cr, input logic inj, input logic rdy,
                                input logic bz, input logic dv, input logic und,
                                input logic [OW-1:0] dg);
        rec_t r;
        r.cr = cr; r.inj = inj; r.rdy = rdy; r.bz = bz; r.dv = dv; r.und = und; r.dig = dg;
        return r;
    endfunction

    // Single compare process: one expected record per cycle while a hash runs.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            chk_b("core_reset", core_reset, ce.cr);
            chk_b("core_injector", core_injector, ce.inj);
            chk_b("s_ready", s_ready, ce.rdy);
            chk_b("busy", busy, ce.bz);
            chk_b("digest_valid", digest_valid, ce.dv);
            chk_b("underrun", underrun, ce.und);
            chk_w("digest", digest, ce.dig);
        end
    end

    // Model: the injector stream is a list of per-edge events after FEED entry.
    // Word 0 gets d bubbles then a load edge; a later word with d drop cycles
    // costs d-1 bubbles plus a load edge after the previous word's final bit.
    task automatic run_hash(input int nw, input int rdly, input bit fixed_o,
                            input bit start_done, input int abort_at);
        bit            e_inj[$], e_bub[$], e_rdy[$];
        logic [OW-1:0] cov[$];
        rec_t          recs[$];
        int            len, c, total, k, dr, rcnt;
        bit            und, pending, rel, done;
        for (int kk = 0; kk < nw; kk++) begin
            if (kk == 0) begin
                for (int b = 0; b < d_arr[0]; b++) begin
                    e_inj.push_back(0); e_bub.push_back(1); e_rdy.push_back(1);
                end
                e_inj.push_back(0); e_bub.push_back(0); e_rdy.push_back(1);
            end else if (d_arr[kk] >= 1) begin
                for (int b = 0; b < d_arr[kk] - 1; b++) begin
                    e_inj.push_back(0); e_bub.push_back(1); e_rdy.push_back(1);
                end
                e_inj.push_back(0); e_bub.push_back(0); e_rdy.push_back(1);
            end
            for (int i = DW - 1; i >= 0; i--) begin
                e_inj.push_back(w_arr[kk][i]);
                e_bub.push_back(0);
                e_rdy.push_back((i == 0) && (kk < nw - 1));
            end
        end
        len   = e_inj.size();
        c     = WU + len + FL;
        total = c + rdly + 1;
        for (int n = 0; n <= total + 2; n++)
            cov.push_back(fixed_o ? (32'h1234_5678 + 32'(n) * 32'h0101_0101) : $urandom);
        for (int n = 0; n < WU; n++) recs.push_back(mk(0, 0, 0, 1, 0, 0, prev_dig));
        recs.push_back(mk(0, 0, 1, 1, 0, 0, prev_dig));
        und = 0;
        for (int j = 1; j <= len; j++) begin
            und = und | e_bub[j-1];
            recs.push_back(mk(0, e_inj[j-1], (j < len) ? e_rdy[j] : 1'b0, 1, 0, und, prev_dig));
        end
        for (int f = 1; f <= FL; f++)
            recs.push_back(mk(0, 0, 0, 1, f == FL, und, (f == FL) ? cov[c] : prev_dig));
        for (int r = 0; r < rdly; r++) recs.push_back(mk(0, 0, 0, 1, 1, und, cov[c]));
        recs.push_back(mk(1, 0, 0, 0, 0, und, cov[c]));

        @(negedge clk);
        start = 1; s_valid = 0; core_o = cov[0];
        k = 0; dr = d_arr[0]; pending = 0; rel = 0; done = 0; rcnt = 0; inj_log = '0;
        @(posedge clk);
        #1;
        start = 0;
        exp_q = recs;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (n == abort_at) begin
                exp_q.delete();
                #2 rst = 1;
                #1;
                chk_b("abort core_reset", core_reset, 1'b1);
                chk_b("abort s_ready", s_ready, 1'b0);
                chk_b("abort core_injector", core_injector, 1'b0);
                chk_b("abort digest_valid", digest_valid, 1'b0);
                chk_b("abort busy", busy, 1'b0);
                s_valid = 0; start = 0;
                @(posedge clk);
                @(negedge clk);
                rst = 0;
                prev_dig = '0;
                return;
            end
            if (n >= WU + 2 && n < WU + 18) inj_log = {inj_log[30:0], core_injector};
            if (n + 1 < cov.size()) core_o = cov[n+1];
            if (rel) begin
                digest_ready = 0; start = 0; done = 1;
                break;
            end
            if (pending) begin
                k++; s_valid = 0;
                if (k < nw) dr = d_arr[k];
            end
            if (k < nw && !s_valid && s_ready) begin
                if (dr == 0) begin
                    s_valid = 1; s_data = w_arr[k]; s_last = (k == nw - 1);
                end else dr--;
            end
            pending = s_valid && s_ready;
            if (digest_valid) begin
                if (start_done) start = 1;
                if (rcnt == rdly) begin digest_ready = 1; rel = 1; end
                else rcnt++;
            end
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL hash_timeout: actual no release expected release within 600 cycles");
            digest_ready = 0; start = 0; s_valid = 0;
        end
        @(posedge clk);
        chk_w("trace_length_left", exp_q.size(), 0);
        exp_q.delete();
        prev_dig = cov[c];
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_b("rst core_reset", core_reset, 1'b1);
        chk_b("rst core_injector", core_injector, 1'b0);
        chk_b("rst s_ready", s_ready, 1'b0);
        chk_b("rst busy", busy, 1'b0);
        chk_b("rst digest_valid", digest_valid, 1'b0);
        chk_b("rst underrun", underrun, 1'b0);
        chk_w("rst digest", digest, 32'h0);
        rst = 0;
        repeat (2) @(negedge clk);

        w_arr[0] = 8'hA5; d_arr[0] = 0;
        run_hash(1, 0, 1, 0, -1);
        chk_w("single digest", digest, 32'h2749_6B8D);
        chk_w("single bits", inj_log[15:0], 32'h0000_A500);
        chk_b("single underrun", underrun, 1'b0);

        w_arr[0] = 8'hFF; w_arr[1] = 8'h00; w_arr[2] = 8'h81;
        d_arr[0] = 0; d_arr[1] = 0; d_arr[2] = 0;
        run_hash(3, 1, 1, 0, -1);
        chk_w("b2b digest", digest, 32'h3759_7B9D);
        chk_w("b2b bits", inj_log[15:0], 32'h0000_FF00);
        chk_b("b2b underrun", underrun, 1'b0);

        w_arr[0] = 8'h0F; w_arr[1] = 8'hF0; d_arr[0] = 0; d_arr[1] = 3;
        run_hash(2, 0, 1, 0, -1);
        chk_w("stall digest", digest, 32'h3254_7698);
        chk_w("stall bits", inj_log[15:0], 32'h0000_0F1E);
        chk_b("stall underrun", underrun, 1'b1);

        w_arr[0] = 8'hA5; d_arr[0] = 0;
        run_hash(1, 20, 1, 1, -1);
        chk_w("hold digest", digest, 32'h2749_6B8D);

        run_hash(1, 0, 1, 0, WU + 4);
        chk_w("abort digest cleared", digest, 32'h0);
        run_hash(1, 0, 1, 0, -1);
        chk_w("post-abort digest", digest, 32'h2749_6B8D);

        for (int r = 0; r < 8; r++) begin
            int nw;
            nw = $urandom_range(1, 4);
            for (int k = 0; k < nw; k++) begin
                w_arr[k] = DW'($urandom);
                d_arr[k] = (k == 0) ? $urandom_range(0, 2) : $urandom_range(0, 3);
            end
            run_hash(nw, $urandom_range(0, 3), 0, 1'($urandom_range(0, 1)), -1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hash_message_feeder.md
Name: hash_message_feeder

Overview:
- Initiator-side driver for the programmable hash core.
- Accepts message words on a valid/ready stream, holds the core in reset while idle, and releases it for a fixed warm-up so the config registers settle.
- Serializes each word MSB-first onto the core's single injector bit, then injects zero padding for a fixed flush length.
- Captures the core output O as the digest and presents it on a valid/ready handshake.

Parameters:
- DATA_W, 8, message word width.
- OUT_SIZE, 32, hash core output width (= lfsr_out_size).
- WARMUP_CYCLES, 64, cycles between core reset release and the first injected bit (>=1).
- FLUSH_CYCLES, 128, zero-injection cycles after the last message bit (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a hash; sampled only in IDLE.
- busy  out  1  high when state != IDLE.
- s_data  in  DATA_W  message word.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks the final word; qualified by the handshake.
- s_ready  out  1  word accepted when s_valid && s_ready.
- core_reset  out  1  drives the core reset; registered.
- core_injector  out  1  drives the core's lfsr_in_injector; registered.
- core_O  in  OUT_SIZE  core output O.
- digest  out  OUT_SIZE  captured hash value.
- digest_valid  out  1  digest available.
- digest_ready  in  1  consumer accepts the digest.
- underrun  out  1  sticky: a bubble bit was injected during this hash; valid with digest.

Behaviour:
- Reset values: state IDLE, core_reset=1, core_injector=0, s_ready=0, digest=0, digest_valid=0, underrun=0, busy=0.
- States: IDLE, WARMUP, FEED, FLUSH, DONE.
- IDLE:
  - core_reset=1, core_injector=0.
  - On start: go to WARMUP, load cnt=WARMUP_CYCLES-1, set core_reset=0 at the same edge, clear underrun.
  - s_valid is ignored.
- WARMUP:
  - cnt decrements each cycle.
  - At cnt==0, go to FEED. Duration is exactly WARMUP_CYCLES cycles.
- FEED:
  - Holds a DATA_W shift register sr, bits_left counter, and a last_pending flag.
  - s_ready = (bits_left==0 || bits_left==1) && !last_pending. This allows back-to-back words with no gap bit.
  - On handshake: sr<=s_data, bits_left<=DATA_W, last_pending<=s_last.
  - Each cycle with bits_left>0: core_injector<=sr[DATA_W-1], sr shifts left, bits_left decrements.
  - Each cycle with bits_left==0 and no handshake, before last is seen: core_injector<=0 and underrun<=1. This includes the first FEED cycle; a word presented at FEED entry is loaded there, and its MSB drives the injector one cycle later.
  - First data bit is visible on core_injector 1 cycle after the accepting edge.
  - When the final bit of the last_pending word is driven (bits_left==1 && last_pending): go to FLUSH, cnt=FLUSH_CYCLES-1.
- FLUSH:
  - core_injector<=0 each cycle; cnt decrements.
  - At the edge where cnt==0: digest<=core_O, digest_valid<=1, go to DONE.
  - Duration is FLUSH_CYCLES cycles of 0 on the injector.
- DONE:
  - digest, digest_valid and underrun are held stable.
  - start is ignored.
  - On digest_valid && digest_ready: digest_valid<=0, core_reset<=1, go to IDLE. digest keeps its value until the next capture.
- Messages are at least 1 word; a zero-length message is not supported.
- s_last is meaningful only on a handshake.
- Asynchronous reset mid-operation:
  - All outputs take their reset values immediately.
  - The core is re-held in reset.
  - A partially fed message is discarded.
- Counter width: cnt is $clog2(max(WARMUP_CYCLES, FLUSH_CYCLES)+1) bits; bits_left is $clog2(DATA_W+1) bits.

Decomposition:
- Package hash_feeder_pkg holds:
  - feeder_state_t enum (IDLE, WARMUP, FEED, FLUSH, DONE).
  - a cnt_width function.
- Sub-module hash_bit_serializer implements the piso function: sr, bits_left and last_pending, the load/shift and s_ready logic, and a bubble output.
- The FSM and counters live in the top.

Test Plan (WARMUP_CYCLES=4, FLUSH_CYCLES=8, DATA_W=8):
- Single word 0xA5 with s_last=1 presented at FEED entry, start at edge 0:
  - core_reset falls at edge 0 and stays low for 4 WARMUP cycles.
  - core_injector then shows 1,0,1,0,0,1,0,1 followed by 8 zeros.
  - digest equals core_O sampled at the final FLUSH edge; underrun=0.
- Three words 0xFF, 0x00, 0x81 (last) held valid continuously:
  - 24 contiguous bits with no gap, s_ready high only at bits_left<=1, underrun=0.
- Stall: word 0x0F, then s_valid dropped for 3 cycles, then 0xF0 (last):
  - 3 injected 0 bits between the words, underrun=1 at digest_valid.
- digest_ready held low for 20 cycles with start pulsed:
  - digest_valid and digest stay stable, start is ignored, busy=1, core_reset=0.
  - Releasing digest_ready returns to IDLE and sets core_reset=1 next cycle.
- reset asserted mid-FEED after 3 bits:
  - core_reset=1, s_ready=0, core_injector=0 and digest_valid=0 immediately.
  - A subsequent start completes a fresh hash whose digest matches the single-word run.
